// File: rtl/glitch_pkg.sv
// Shared types for the glitchless read responder.
// State codes carry ws/dv directly in bits [3:2], so outputs need no decode.
package glitch_pkg;

    localparam int WS_BIT = 3;
    localparam int DV_BIT = 2;

    typedef enum logic [3:0] {
        R_IDLE  = 4'b00_00,
        R_WAIT  = 4'b10_01,
        R_READY = 4'b01_10
    } resp_state_t;

endpackage

// File: rtl/glitchless_resp_if.sv
// rd/ds/ws read-strobe bus between a glitchless read initiator and its responder.
// The master modport is the initiator side; the slave modport is the responder side.
interface glitchless_resp_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int WAIT_W = 3
);
    logic              rd;
    logic              ds;
    logic [ADDR_W-1:0] addr;
    logic [WAIT_W-1:0] wait_cfg;
    logic              ws;
    logic              dv;
    logic [DATA_W-1:0] rdata;

    modport master (output rd, ds, addr, wait_cfg, input ws, dv, rdata);
    modport slave  (input rd, ds, addr, wait_cfg, output ws, dv, rdata);
endinterface

// File: rtl/resp_regfile.sv
// Backdoor-writable register file serving as the read target.
// One synchronous write port and a combinational read port, so a same-edge write is not seen.
module resp_regfile #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];
endmodule

// File: rtl/glitchless_resp.sv
// Responder for the rd/ds/ws read protocol: counts programmable wait states,
// then holds registered read data with dv until the initiator's ds strobe.
module glitchless_resp
    import glitch_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WAIT_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    glitchless_resp_if.slave  bus,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_waddr,
    input  logic [DATA_W-1:0] cfg_wdata
);
    resp_state_t       state_reg, state_next;
    logic [WAIT_W-1:0] count_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              capture;
    logic              ws;
    logic              dv;

    // A zero-wait request captures on the request edge, before addr is latched.
    assign mem_raddr = (state_reg == R_IDLE) ? bus.addr : addr_reg;

    resp_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (cfg_we),
        .waddr   (cfg_waddr),
        .wdata   (cfg_wdata),
        .raddr   (mem_raddr),
        .rdata   (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= R_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            R_IDLE: begin
                if (bus.rd) begin
                    state_next = (bus.wait_cfg == '0) ? R_READY : R_WAIT;
                end
            end
            R_WAIT: begin
                if (!bus.rd) begin
                    state_next = R_IDLE;
                end else if (count_reg == WAIT_W'(1)) begin
                    state_next = R_READY;
                end
            end
            R_READY: begin
                if (bus.ds || !bus.rd) begin
                    state_next = R_IDLE;
                end
            end
            default: state_next = R_IDLE;
        endcase
    end

    always_comb begin
        ws = state_reg[WS_BIT];
        dv = state_reg[DV_BIT];
    end

    assign capture = bus.rd &&
                     (((state_reg == R_IDLE) && (bus.wait_cfg == '0)) ||
                      ((state_reg == R_WAIT) && (count_reg == WAIT_W'(1))));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
            addr_reg  <= '0;
            rdata_reg <= '0;
        end else begin
            if ((state_reg == R_IDLE) && bus.rd) begin
                count_reg <= bus.wait_cfg;
                addr_reg  <= bus.addr;
            end else if ((state_reg == R_WAIT) && bus.rd && (count_reg != WAIT_W'(1))) begin
                count_reg <= count_reg - WAIT_W'(1);
            end
            if (capture) begin
                rdata_reg <= mem_rdata;
            end
        end
    end

    assign bus.ws    = ws;
    assign bus.dv    = dv;
    assign bus.rdata = rdata_reg;
endmodule

// File: tb/tb_glitchless_resp.sv
// Directed bench for glitchless_resp: a behavioural initiator drives the
// READ/DLY/DONE/IDLE sequence and every cycle is compared to hand-derived timing.
module tb_glitchless_resp;
    import glitch_pkg::*;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       cfg_we    = 1'b0;
    logic [3:0] cfg_waddr = '0;
    logic [7:0] cfg_wdata = '0;
    int         checks    = 0;
    int         errors    = 0;

    glitchless_resp_if #(.DATA_W(8), .ADDR_W(4), .WAIT_W(3)) bus ();

    glitchless_resp #(
        .DATA_W (8),
        .DEPTH  (16),
        .ADDR_W (4),
        .WAIT_W (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .cfg_we    (cfg_we),
        .cfg_waddr (cfg_waddr),
        .cfg_wdata (cfg_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_waddr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    // One initiator read starting at t0; optional backdoor write held high during cycle wr_cyc.
    task automatic init_read(input string tag, input logic [3:0] a, input logic [2:0] wc,
                             input logic [7:0] exp_d, input int exp_done,
                             input int wr_cyc, input logic [3:0] wa, input logic [7:0] wd);
        int t       = 0;
        bit go_done = 1'b0;
        int done_t  = -1;
        int dv_from = (wc == 0) ? 1 : int'(wc) + 1;
        bus.addr = a; bus.wait_cfg = wc; bus.ds = 1'b0; bus.rd = 1'b1;
        cfg_we = (wr_cyc == 0); cfg_waddr = wa; cfg_wdata = wd;
        while (done_t < 0 && t < 16) begin
            tick();
            t++;
            cfg_we = (t == wr_cyc);
            chk({tag, "_ws"}, 32'(bus.ws), 32'(t >= 1 && t <= int'(wc)));
            chk({tag, "_dv"}, 32'(bus.dv), 32'(t >= dv_from));
            if (go_done) begin
                done_t = t;
                bus.rd = 1'b0;
                bus.ds = 1'b1;
                chk({tag, "_rdata"}, 32'(bus.rdata), 32'(exp_d));
            end else if (t % 2 == 1) begin
                go_done = !bus.ws;
            end
        end
        chk({tag, "_done_t"}, 32'(done_t), 32'(exp_done));
        tick();
        bus.ds = 1'b0;
        cfg_we = 1'b0;
        chk({tag, "_idle_dv"}, 32'(bus.dv), 32'(0));
        tick();
        $display("read %s addr=%0h wait=%0d done_t=%0d rdata=%0h", tag, a, wc, done_t, bus.rdata);
    endtask

    initial begin
        bus.rd = 1'b0; bus.ds = 1'b0; bus.addr = '0; bus.wait_cfg = '0;
        #12;
        chk("rst_ws", 32'(bus.ws), 32'(0));
        chk("rst_dv", 32'(bus.dv), 32'(0));
        chk("rst_rdata", 32'(bus.rdata), 32'(0));
        reset_n = 1'b1;
        tick();

        wr(4'd3, 8'hA5);
        init_read("zero_wait", 4'd3, 3'd0, 8'hA5, 2, -1, 4'd0, 8'h00);

        // Asynchronous reset in the middle of a wait sequence.
        bus.addr = 4'd3; bus.wait_cfg = 3'd5; bus.rd = 1'b1;
        tick();
        tick();
        chk("rstmid_pre_ws", 32'(bus.ws), 32'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_ws", 32'(bus.ws), 32'(0));
        chk("rstmid_dv", 32'(bus.dv), 32'(0));
        chk("rstmid_rdata", 32'(bus.rdata), 32'(0));
        chk("rstmid_state", 32'(dut.state_reg), 32'(R_IDLE));
        $display("reset mid-wait ws=%0b dv=%0b rdata=%0h", bus.ws, bus.dv, bus.rdata);
        bus.rd = 1'b0;
        tick();
        #2 reset_n = 1'b1;
        tick();

        wr(4'd7, 8'h3C);
        init_read("wait3", 4'd7, 3'd3, 8'h3C, 6, -1, 4'd0, 8'h00);

        // Abort: rd dropped during t2 of a four-wait request.
        bus.addr = 4'd5; bus.wait_cfg = 3'd4; bus.rd = 1'b1;
        tick();
        chk("abort_t1_ws", 32'(bus.ws), 32'(1));
        tick();
        chk("abort_t2_ws", 32'(bus.ws), 32'(1));
        bus.rd = 1'b0;
        tick();
        chk("abort_ws", 32'(bus.ws), 32'(0));
        chk("abort_dv", 32'(bus.dv), 32'(0));
        chk("abort_rdata", 32'(bus.rdata), 32'(8'h3C));
        chk("abort_state", 32'(dut.state_reg), 32'(R_IDLE));
        $display("abort ws=%0b dv=%0b rdata=%0h", bus.ws, bus.dv, bus.rdata);
        tick();

        wr(4'd2, 8'h11);
        init_read("wr_early", 4'd2, 3'd2, 8'h22, 4, 1, 4'd2, 8'h22);
        wr(4'd2, 8'h11);
        init_read("wr_capture", 4'd2, 3'd2, 8'h11, 4, 2, 4'd2, 8'h22);
        init_read("wr_after", 4'd2, 3'd0, 8'h22, 2, -1, 4'd0, 8'h00);

        wr(4'd0, 8'h01);
        wr(4'd15, 8'hFE);
        init_read("b2b_first", 4'd0, 3'd1, 8'h01, 4, -1, 4'd0, 8'h00);
        init_read("b2b_second", 4'd15, 3'd0, 8'hFE, 2, -1, 4'd0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
